hyper_nd_trans_splitter: RTL and testbench

//  Next-generation 2D transfer splitter in the uDMA HyperBus request path, between the channel/config front-end
//  and the hyper controller. Accepts one (optionally 2D on the L2 and/or external side) transfer and emits 1D chunks.

---
 rtl/hyper_nd_trans_splitter.sv | 204 ++++++++++++++++++++
 tb/tb_hyper_nd_trans_splitter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hyper_nd_trans_splitter.sv
// hyper_nd_trans_splitter: splits one 1D/2D uDMA HyperBus transfer into 1D chunks
// bounded by L2 row ends, external row ends and external burst boundaries. Rev 1.0
`default_nettype none

module hyper_nd_trans_splitter #(
  parameter int L2_AWIDTH_NOAL = 12,
  parameter int TRANS_SIZE     = 16,
  parameter int ID_WIDTH       = 1,
  parameter int CFG_WIDTH      = 80,
  parameter int BURST_BYTES    = 512
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      src_valid_i,
  output logic                      src_ready_o,
  input  logic [L2_AWIDTH_NOAL-1:0] src_l2_addr_i,
  input  logic [31:0]               src_ext_addr_i,
  input  logic [TRANS_SIZE-1:0]     src_size_i,
  input  logic                      src_rw_i,
  input  logic [ID_WIDTH-1:0]       src_id_i,
  input  logic                      ext_act_i,
  input  logic [TRANS_SIZE-1:0]     ext_count_i,
  input  logic [TRANS_SIZE-1:0]     ext_stride_i,
  input  logic                      l2_act_i,
  input  logic [TRANS_SIZE-1:0]     l2_count_i,
  input  logic [TRANS_SIZE-1:0]     l2_stride_i,
  input  logic [CFG_WIDTH-1:0]      cfg_i,
  output logic                      dst_valid_o,
  input  logic                      dst_ready_i,
  output logic [L2_AWIDTH_NOAL-1:0] dst_l2_addr_o,
  output logic [31:0]               dst_ext_addr_o,
  output logic [TRANS_SIZE-1:0]     dst_size_o,
  output logic                      dst_rw_o,
  output logic [ID_WIDTH:0]         dst_id_o,
  output logic                      dst_last_o,
  output logic [CFG_WIDTH-1:0]      cfg_o
);

  localparam int LW = TRANS_SIZE + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CALC  = 2'd1;
  localparam logic [1:0] ISSUE = 2'd2;

  logic [1:0] state;
  logic [1:0] state_next;

  logic [TRANS_SIZE-1:0]     rem;
  logic [31:0]               ext_addr;
  logic [31:0]               ext_base;
  logic [TRANS_SIZE-1:0]     ext_off;
  logic [TRANS_SIZE-1:0]     ext_count;
  logic [TRANS_SIZE-1:0]     ext_stride;
  logic                      ext_act;
  logic [L2_AWIDTH_NOAL-1:0] l2_addr;
  logic [L2_AWIDTH_NOAL-1:0] l2_base;
  logic [TRANS_SIZE-1:0]     l2_off;
  logic [TRANS_SIZE-1:0]     l2_count;
  logic [TRANS_SIZE-1:0]     l2_stride;
  logic                      l2_act;
  logic                      rw;
  logic [ID_WIDTH-1:0]       id;
  logic [CFG_WIDTH-1:0]      cfg;
  logic [TRANS_SIZE-1:0]     dst_size;
  logic                      dst_last;

  logic          accept;
  logic          handshake;
  logic [LW-1:0] len_rem;
  logic [LW-1:0] len_ext;
  logic [LW-1:0] len_l2;
  logic [LW-1:0] len_burst;
  logic [LW-1:0] len_min;
  logic          ext_row_end;
  logic          l2_row_end;
  logic [31:0]               ext_base_next;
  logic [L2_AWIDTH_NOAL-1:0] l2_base_next;

  assign accept    = (state == IDLE) && src_valid_i;
  assign handshake = (state == ISSUE) && dst_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_next;
  end

  // A zero-size request is absorbed without leaving IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (src_valid_i && (src_size_i != '0)) state_next = CALC;
      CALC:    state_next = ISSUE;
      ISSUE:   if (dst_ready_i) state_next = dst_last ? IDLE : CALC;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    src_ready_o = (state == IDLE);
    dst_valid_o = (state == ISSUE);
    dst_id_o    = (state == IDLE) ? {1'b1, {ID_WIDTH{1'b0}}} : {1'b0, id};
  end

  generate
    if (BURST_BYTES == 0) begin : g_no_burst
      assign len_burst = '1;
    end else if (BURST_BYTES == 1) begin : g_burst_one
      assign len_burst = LW'(1);
    end else begin : g_burst
      localparam int BW = $clog2(BURST_BYTES);
      logic [BW-1:0] burst_off;
      assign burst_off = ext_addr[BW-1:0];
      assign len_burst = LW'(BURST_BYTES) - LW'(burst_off);
    end
  endgenerate

  // Row offsets stay below the row count, so these differences never go negative.
  assign len_rem = {1'b0, rem};
  assign len_ext = ext_act ? ({1'b0, ext_count} - {1'b0, ext_off}) : '1;
  assign len_l2  = l2_act  ? ({1'b0, l2_count}  - {1'b0, l2_off})  : '1;

  always_comb begin
    len_min = len_rem;
    if (len_ext   < len_min) len_min = len_ext;
    if (len_l2    < len_min) len_min = len_l2;
    if (len_burst < len_min) len_min = len_burst;
  end

  assign ext_row_end   = ext_act && (({1'b0, ext_off} + {1'b0, dst_size}) == {1'b0, ext_count});
  assign l2_row_end    = l2_act  && (({1'b0, l2_off}  + {1'b0, dst_size}) == {1'b0, l2_count});
  assign ext_base_next = ext_base + 32'(ext_stride);
  assign l2_base_next  = l2_base + L2_AWIDTH_NOAL'(l2_stride);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rem        <= '0;
      ext_addr   <= '0;
      ext_base   <= '0;
      ext_off    <= '0;
      ext_count  <= '0;
      ext_stride <= '0;
      ext_act    <= 1'b0;
      l2_addr    <= '0;
      l2_base    <= '0;
      l2_off     <= '0;
      l2_count   <= '0;
      l2_stride  <= '0;
      l2_act     <= 1'b0;
      rw         <= 1'b0;
      id         <= '0;
      cfg        <= '0;
      dst_size   <= '0;
      dst_last   <= 1'b0;
    end else if (accept) begin
      rem        <= src_size_i;
      ext_addr   <= src_ext_addr_i;
      ext_base   <= src_ext_addr_i;
      ext_off    <= '0;
      ext_count  <= ext_count_i;
      ext_stride <= ext_stride_i;
      ext_act    <= ext_act_i && (ext_count_i != '0);
      l2_addr    <= src_l2_addr_i;
      l2_base    <= src_l2_addr_i;
      l2_off     <= '0;
      l2_count   <= l2_count_i;
      l2_stride  <= l2_stride_i;
      l2_act     <= l2_act_i && (l2_count_i != '0);
      rw         <= src_rw_i;
      id         <= src_id_i;
      cfg        <= cfg_i;
    end else if (state == CALC) begin
      dst_size <= len_min[TRANS_SIZE-1:0];
      dst_last <= (len_min == len_rem);
    end else if (handshake) begin
      rem <= rem - dst_size;
      if (ext_row_end) begin
        ext_base <= ext_base_next;
        ext_addr <= ext_base_next;
        ext_off  <= '0;
      end else begin
        ext_addr <= ext_addr + 32'(dst_size);
        ext_off  <= ext_off + dst_size;
      end
      if (l2_row_end) begin
        l2_base <= l2_base_next;
        l2_addr <= l2_base_next;
        l2_off  <= '0;
      end else begin
        l2_addr <= l2_addr + L2_AWIDTH_NOAL'(dst_size);
        l2_off  <= l2_off + dst_size;
      end
    end
  end

  assign dst_l2_addr_o  = l2_addr;
  assign dst_ext_addr_o = ext_addr;
  assign dst_size_o     = dst_size;
  assign dst_rw_o       = rw;
  assign dst_last_o     = dst_last;
  assign cfg_o          = cfg;

endmodule

`default_nettype wire

// File: tb/tb_hyper_nd_trans_splitter.sv
// tb_hyper_nd_trans_splitter: table vectors, hand-written corner sequences and randomized
// transfers checked against a position-based chunking model. Rev 1.0
`default_nettype none

module tb_hyper_nd_trans_splitter;

  localparam int BURST = 512;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        src_valid_i = 1'b0;
  logic        src_ready_o;
  logic [11:0] src_l2_addr_i = '0;
  logic [31:0] src_ext_addr_i = '0;
  logic [15:0] src_size_i = '0;
  logic        src_rw_i = 1'b0;
  logic [0:0]  src_id_i = '0;
  logic        ext_act_i = 1'b0;
  logic [15:0] ext_count_i = '0;
  logic [15:0] ext_stride_i = '0;
  logic        l2_act_i = 1'b0;
  logic [15:0] l2_count_i = '0;
  logic [15:0] l2_stride_i = '0;
  logic [79:0] cfg_i = '0;
  logic        dst_valid_o;
  logic        dst_ready_i = 1'b0;
  logic [11:0] dst_l2_addr_o;
  logic [31:0] dst_ext_addr_o;
  logic [15:0] dst_size_o;
  logic        dst_rw_o;
  logic [1:0]  dst_id_o;
  logic        dst_last_o;
  logic [79:0] cfg_o;

  hyper_nd_trans_splitter #(
    .L2_AWIDTH_NOAL(12), .TRANS_SIZE(16), .ID_WIDTH(1), .CFG_WIDTH(80), .BURST_BYTES(BURST)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .src_valid_i(src_valid_i), .src_ready_o(src_ready_o),
    .src_l2_addr_i(src_l2_addr_i), .src_ext_addr_i(src_ext_addr_i), .src_size_i(src_size_i),
    .src_rw_i(src_rw_i), .src_id_i(src_id_i),
    .ext_act_i(ext_act_i), .ext_count_i(ext_count_i), .ext_stride_i(ext_stride_i),
    .l2_act_i(l2_act_i), .l2_count_i(l2_count_i), .l2_stride_i(l2_stride_i),
    .cfg_i(cfg_i),
    .dst_valid_o(dst_valid_o), .dst_ready_i(dst_ready_i),
    .dst_l2_addr_o(dst_l2_addr_o), .dst_ext_addr_o(dst_ext_addr_o), .dst_size_o(dst_size_o),
    .dst_rw_o(dst_rw_o), .dst_id_o(dst_id_o), .dst_last_o(dst_last_o), .cfg_o(cfg_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [11:0] l2;
    logic [31:0] ext;
    logic [15:0] size;
    logic        rw;
    logic [0:0]  id;
    logic        eact;
    logic [15:0] ec;
    logic [15:0] es;
    logic        lact;
    logic [15:0] lc;
    logic [15:0] ls;
    logic [79:0] cfg;
  } req_t;

  typedef struct packed {
    req_t             r;
    logic [2:0]       n;
    logic [3:0][15:0] sz;
    logic [3:0][31:0] ea;
    logic [3:0][11:0] la;
  } vec_t;

  int total = 0;
  int bad = 0;
  longint exp_sz[$];
  longint exp_ea[$];
  longint exp_la[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Chunk k starts at byte position p; its addresses follow from p's row/column.
  task automatic model(input req_t r);
    longint p, len, ea, la, cap;
    bit eact, lact;
    eact = r.eact && (r.ec != 0);
    lact = r.lact && (r.lc != 0);
    exp_sz.delete(); exp_ea.delete(); exp_la.delete();
    p = 0;
    while (p < longint'(r.size)) begin
      len = longint'(r.size) - p;
      if (eact) begin
        ea  = longint'(r.ext) + (p / r.ec) * r.es + (p % r.ec);
        cap = r.ec - (p % r.ec);
        if (cap < len) len = cap;
      end else ea = longint'(r.ext) + p;
      if (lact) begin
        la  = longint'(r.l2) + (p / r.lc) * r.ls + (p % r.lc);
        cap = r.lc - (p % r.lc);
        if (cap < len) len = cap;
      end else la = longint'(r.l2) + p;
      ea = ea % (64'd1 << 32);
      la = la % 4096;
      cap = BURST - (ea % BURST);
      if (cap < len) len = cap;
      exp_sz.push_back(len); exp_ea.push_back(ea); exp_la.push_back(la);
      p += len;
    end
  endtask

  task automatic send(input req_t r);
    int w = 0;
    while (!src_ready_o && w < 100) begin tick(); w++; end
    if (!src_ready_o) check("src_ready_timeout", 0, 1);
    src_l2_addr_i = r.l2; src_ext_addr_i = r.ext; src_size_i = r.size;
    src_rw_i = r.rw; src_id_i = r.id; cfg_i = r.cfg;
    ext_act_i = r.eact; ext_count_i = r.ec; ext_stride_i = r.es;
    l2_act_i = r.lact; l2_count_i = r.lc; l2_stride_i = r.ls;
    src_valid_i = 1'b1;
    tick();
    src_valid_i = 1'b0;
    // scramble inputs to prove they were latched at accept
    src_l2_addr_i = 12'($urandom); src_ext_addr_i = $urandom; src_size_i = 16'($urandom);
    ext_count_i = 16'($urandom); l2_count_i = 16'($urandom); cfg_i = '1;
  endtask

  task automatic collect(input bit rnd, input req_t r, input bit chk_lat);
    int cyc = 1;
    int k = 0;
    int n = exp_sz.size();
    bit stalled = 0;
    logic rdy;
    logic [63:0] snap = '0;
    while (k < n && cyc < 5000) begin
      if (chk_lat && k == 0 && cyc <= 2) check("latency", dst_valid_o, (cyc == 2));
      if (stalled) begin
        check("hold_valid", dst_valid_o, 1);
        check("hold_fields", {dst_size_o, dst_ext_addr_o, dst_l2_addr_o, dst_last_o}, snap);
      end
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      dst_ready_i = rdy;
      stalled = 0;
      if (dst_valid_o) begin
        if (rdy) begin
          check("size", dst_size_o, exp_sz[k]);
          check("ext_addr", dst_ext_addr_o, exp_ea[k]);
          check("l2_addr", dst_l2_addr_o, exp_la[k]);
          check("last", dst_last_o, (k == n - 1));
          check("rw_id_cfg", {dst_rw_o, dst_id_o, cfg_o}, {r.rw, 1'b0, r.id, r.cfg});
          k++;
        end else begin
          stalled = 1;
          snap = {dst_size_o, dst_ext_addr_o, dst_l2_addr_o, dst_last_o};
        end
      end
      tick();
      cyc++;
    end
    dst_ready_i = 1'b0;
    if (k < n) check("chunk_timeout", k, n);
    check("done_valid", dst_valid_o, 0);
    check("done_ready", src_ready_o, 1);
    check("done_id", dst_id_o, 2'b10);
  endtask

  function automatic req_t mk(input logic [11:0] l2, input logic [31:0] ext, input logic [15:0] size,
                              input logic eact, input logic [15:0] ec, input logic [15:0] es,
                              input logic lact, input logic [15:0] lc, input logic [15:0] ls);
    req_t r;
    r.l2 = l2; r.ext = ext; r.size = size; r.rw = 1'b0; r.id = 1'b1;
    r.eact = eact; r.ec = ec; r.es = es; r.lact = lact; r.lc = lc; r.ls = ls;
    r.cfg = 80'h1234_5678_9ABC_DEF0_1357;
    return r;
  endfunction

  vec_t vecs[5];
  req_t rq;

  initial begin
    vecs[0].r = mk(12'h100, 32'h10, 100, 0, 0, 0, 0, 0, 0);
    vecs[0].n = 1; vecs[0].sz = {16'd0, 16'd0, 16'd0, 16'd100};
    vecs[0].ea = {32'd0, 32'd0, 32'd0, 32'h10}; vecs[0].la = {12'd0, 12'd0, 12'd0, 12'h100};
    vecs[1].r = mk(12'h000, 32'h0, 200, 0, 0, 0, 1, 64, 128);
    vecs[1].n = 4; vecs[1].sz = {16'd8, 16'd64, 16'd64, 16'd64};
    vecs[1].ea = {32'd192, 32'd128, 32'd64, 32'd0}; vecs[1].la = {12'd384, 12'd256, 12'd128, 12'd0};
    vecs[2].r = mk(12'h000, 32'h0, 96, 1, 48, 100, 1, 32, 40);
    vecs[2].n = 4; vecs[2].sz = {16'd32, 16'd16, 16'd16, 16'd32};
    vecs[2].ea = {32'd116, 32'd100, 32'd32, 32'd0}; vecs[2].la = {12'd80, 12'd56, 12'd40, 12'd0};
    vecs[3].r = mk(12'h000, 32'h1F0, 1024, 0, 0, 0, 0, 0, 0);
    vecs[3].n = 3; vecs[3].sz = {16'd0, 16'd496, 16'd512, 16'd16};
    vecs[3].ea = {32'd0, 32'h400, 32'h200, 32'h1F0}; vecs[3].la = {12'd0, 12'd528, 12'd16, 12'd0};
    vecs[4].r = mk(12'h010, 32'h20, 40, 1, 0, 7, 1, 0, 7);
    vecs[4].n = 1; vecs[4].sz = {16'd0, 16'd0, 16'd0, 16'd40};
    vecs[4].ea = {32'd0, 32'd0, 32'd0, 32'h20}; vecs[4].la = {12'd0, 12'd0, 12'd0, 12'h010};

    repeat (2) @(posedge clk_i);
    #1;
    check("rst_ready", src_ready_o, 1);
    check("rst_valid", dst_valid_o, 0);
    check("rst_last", dst_last_o, 0);
    check("rst_id", dst_id_o, 2'b10);
    check("rst_regs", {dst_size_o, dst_ext_addr_o, dst_l2_addr_o}, 0);
    check("rst_cfg", cfg_o, 0);
    rst_ni = 1'b1;
    tick();

    for (int v = 0; v < 5; v++) begin
      exp_sz.delete(); exp_ea.delete(); exp_la.delete();
      for (int c = 0; c < int'(vecs[v].n); c++) begin
        exp_sz.push_back(longint'(vecs[v].sz[c]));
        exp_ea.push_back(longint'(vecs[v].ea[c]));
        exp_la.push_back(longint'(vecs[v].la[c]));
      end
      send(vecs[v].r);
      collect(0, vecs[v].r, 1);
    end

    // ready held low for 5 cycles while a chunk is offered
    send(vecs[0].r);
    tick();
    check("stall_valid", dst_valid_o, 1);
    begin
      logic [63:0] snap;
      snap = {dst_size_o, dst_ext_addr_o, dst_l2_addr_o, dst_last_o};
      for (int i = 0; i < 5; i++) begin
        tick();
        check("stall_hold", {dst_valid_o, dst_size_o, dst_ext_addr_o, dst_l2_addr_o, dst_last_o},
              {1'b1, snap[60:0]});
      end
    end
    dst_ready_i = 1'b1;
    tick();
    dst_ready_i = 1'b0;
    check("stall_release_valid", dst_valid_o, 0);
    check("stall_release_ready", src_ready_o, 1);

    // asynchronous reset while a chunk is offered
    send(vecs[3].r);
    tick();
    check("abort_pre_valid", dst_valid_o, 1);
    rst_ni = 1'b0;
    #2;
    check("abort_valid", dst_valid_o, 0);
    check("abort_ready", src_ready_o, 1);
    rst_ni = 1'b1;
    dst_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort_quiet", {dst_valid_o, src_ready_o}, 2'b01);
    end
    dst_ready_i = 1'b0;

    // zero-size request
    send(mk(12'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0));
    check("zero_ready", src_ready_o, 1);
    for (int i = 0; i < 3; i++) begin
      check("zero_no_valid", dst_valid_o, 0);
      tick();
    end

    for (int t = 0; t < 60; t++) begin
      rq.l2   = 12'($urandom);
      rq.ext  = $urandom;
      rq.size = 16'($urandom_range(0, 300));
      rq.rw   = 1'($urandom);
      rq.id   = 1'($urandom);
      rq.eact = 1'($urandom);
      rq.ec   = 16'($urandom_range(0, 80));
      rq.es   = 16'($urandom_range(0, 200));
      rq.lact = 1'($urandom);
      rq.lc   = 16'($urandom_range(0, 80));
      rq.ls   = 16'($urandom_range(0, 200));
      rq.cfg  = {16'($urandom), $urandom, $urandom};
      model(rq);
      send(rq);
      collect(1, rq, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
